imm_gen_pipe: RTL

Registered, parametrised successor to the combinational immediate generator. Decodes the immediate of a RISC-V instruction for XLEN=32 or 64 and classifies its format. Flags illegal or unsupported encodings and counts them. Sits between fetch and decode as a one-cycle valid/ready pipeline stage with a skid buffer, so throughput is one instruction per cycle under backpressure.

---
 rtl/imm_gen_pkg.sv | 39 +++
 rtl/imm_gen_if.sv | 28 ++
 rtl/imm_decode.sv | 86 ++++++++
 rtl/imm_gen_pipe.sv | 93 +++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared opcodes, immediate format codes and the decoded-entry layout for the
// immediate generator pipeline stage.
package imm_gen_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Entry fields are sized for the widest configuration; narrower instances
  // zero-pad on the way in and truncate on the way out.
  localparam int XLEN_MAX  = 64;
  localparam int TAG_W_MAX = 64;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6,
    FMT_SH   = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0]  imm;
    fmt_e                 fmt;
    logic                 illegal;
    logic [TAG_W_MAX-1:0] tag;
  } entry_t;

endpackage

// File: rtl/imm_gen_if.sv
// Fetch-side and decode-side valid/ready handshake of the immediate generator.
interface imm_gen_if
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  fmt_e             out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate extraction and format classification for
// XLEN=32 or 64.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               is_shift;
  logic signed [31:0] u_imm;
  logic signed [20:0] j_imm;
  logic signed [11:0] i_imm;
  logic signed [11:0] s_imm;
  logic signed [12:0] b_imm;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign u_imm    = {instr[31:12], 12'b0};
  assign j_imm    = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign i_imm    = instr[31:20];
  assign s_imm    = {instr[31:25], instr[11:7]};
  assign b_imm    = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b1;
    if (instr[1:0] == 2'b11) begin
      case (opcode)
        OP_LUI, OP_AUIPC: begin
          imm = XLEN'(u_imm); fmt = FMT_U; illegal = 1'b0;
        end
        OP_JAL: begin
          imm = XLEN'(j_imm); fmt = FMT_J; illegal = 1'b0;
        end
        OP_JALR, OP_LOAD: begin
          imm = XLEN'(i_imm); fmt = FMT_I; illegal = 1'b0;
        end
        OP_IMM: begin
          if (!is_shift) begin
            imm = XLEN'(i_imm); fmt = FMT_I; illegal = 1'b0;
          end else if (XLEN == 64) begin
            imm = XLEN'(instr[25:20]); fmt = FMT_SH; illegal = 1'b0;
          end else begin
            // RV32 shamt is 5 bits; a set bit 25 is a reserved encoding
            imm = XLEN'(instr[24:20]); fmt = FMT_SH; illegal = instr[25];
          end
        end
        OP_IMM_32: begin
          if (XLEN == 64) begin
            if (is_shift) begin
              imm = XLEN'(instr[24:20]); fmt = FMT_SH; illegal = instr[25];
            end else begin
              imm = XLEN'(i_imm); fmt = FMT_I; illegal = 1'b0;
            end
          end
        end
        OP_BRANCH: begin
          imm = XLEN'(b_imm); fmt = FMT_B; illegal = 1'b0;
        end
        OP_STORE: begin
          imm = XLEN'(s_imm); fmt = FMT_S; illegal = 1'b0;
        end
        OP_SYSTEM: begin
          // CSR address and zimm are unsigned fields
          if (funct3[2]) begin
            imm = XLEN'(instr[19:15]); fmt = FMT_Z;
          end else begin
            imm = XLEN'(instr[31:20]); fmt = FMT_I;
          end
          illegal = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// One-cycle valid/ready stage between fetch and decode: registers the decoded
// immediate, absorbs backpressure in a skid entry and counts illegal encodings.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  imm_gen_if.slave         bus,
  output logic [CNT_W-1:0] illegal_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;
  entry_t          ent_p0;
  logic            vld_p0;
  entry_t          out_p1;
  entry_t          skid_p1;
  logic            vld_p1;
  logic            skid_vld_p1;
  logic            stall;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (bus.in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  // p0: combinational decode of the presented instruction
  always_comb begin
    ent_p0.imm     = XLEN_MAX'(dec_imm);
    ent_p0.fmt     = dec_fmt;
    ent_p0.illegal = dec_illegal;
    ent_p0.tag     = TAG_W_MAX'(bus.in_tag);
  end

  assign vld_p0 = bus.in_valid && !skid_vld_p1 && !flush;
  assign stall  = vld_p1 && !bus.out_ready;

  // p1: output register and skid entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (stall) begin
      if (vld_p0) skid_vld_p1 <= 1'b1;
    end else if (skid_vld_p1) begin
      vld_p1      <= 1'b1;
      skid_vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p1 <= '0;
    end else if (!flush && !stall) begin
      if (skid_vld_p1)  out_p1 <= skid_p1;
      else if (vld_p0)  out_p1 <= ent_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && stall && vld_p0) skid_p1 <= ent_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        illegal_cnt <= '0;
    else if (vld_p0 && ent_p0.illegal) illegal_cnt <= sat_inc(illegal_cnt);
  end

  assign bus.in_ready    = !skid_vld_p1;
  assign bus.out_valid   = vld_p1;
  assign bus.out_imm     = XLEN'(out_p1.imm);
  assign bus.out_fmt     = out_p1.fmt;
  assign bus.out_illegal = out_p1.illegal;
  assign bus.out_tag     = TAG_W'(out_p1.tag);

endmodule
